branch_resolver: RTL

Execute-side counterpart to the fetch-stage branch target buffer. Tracks every fetched instruction's BTB prediction in an in-order queue and pops the matching record when that instruction leaves EX. It compares the prediction with the actual branch outcome and produces the BTB install/invalidate write. On a misprediction it issues a one-cycle pipeline flush with the corrected fetch address, and it keeps branch and miss statistics.

---
 rtl/branch_resolver_pkg.sv | 59 +++++
 rtl/branch_resolver_if.sv | 48 ++++
 rtl/branch_resolver_pred_fifo.sv | 52 +++++
 rtl/branch_resolver.sv | 120 ++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// branch_types_pkg: types shared by the branch resolver slice.
//   pred_rec_t : one in-flight BTB prediction {pc, phit, target}
//   res_t      : BTB write decided at resolution (none / install / invalidate)
//   br_state_t : resolver FSM state
//   verdict_t  : result of comparing a prediction with the EX outcome
//   judge()    : the prediction-vs-outcome decision table
package branch_types_pkg;

  // Word-address width the record type is built for (byte PC[31:2]).
  localparam int REC_WADDR = 30;

  typedef struct packed {
    logic [REC_WADDR-1:0] pc;
    logic                 phit;
    logic [REC_WADDR-1:0] target;
  } pred_rec_t;

  typedef enum logic [1:0] {
    RES_OK      = 2'd0,
    RES_INSTALL = 2'd1,
    RES_INVAL   = 2'd2
  } res_t;

  typedef enum logic {
    BR_RUN   = 1'b0,
    BR_FLUSH = 1'b1
  } br_state_t;

  typedef struct packed {
    logic miss;     // fetch went down the wrong path
    res_t res;      // BTB write to perform
    logic use_seq;  // redirect to pc+1 instead of the actual target
  } verdict_t;

  // A hit predicted "taken to target". Anything that was not a taken
  // branch under a hit falls through (invalidate, redirect pc+1); a taken
  // branch that was not predicted, or predicted to the wrong place,
  // installs the real target and redirects there.
  function automatic verdict_t judge(input logic phit, input logic is_br,
                                     input logic taken, input logic tgt_match);
    verdict_t v;
    v = '{miss: 1'b0, res: RES_OK, use_seq: 1'b0};
    if (phit) begin
      if (!is_br || !taken) begin
        v.miss    = 1'b1;
        v.res     = RES_INVAL;
        v.use_seq = 1'b1;
      end else if (!tgt_match) begin
        v.miss = 1'b1;
        v.res  = RES_INSTALL;
      end
    end else if (is_br && taken) begin
      v.miss = 1'b1;
      v.res  = RES_INSTALL;
    end
    return v;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// branch_resolver_if: fetch-side push, EX-side pop and all resolver outputs.
//   master : the pipeline (drives fetch_* and ex_*, observes results)
//   slave  : the resolver
// Handshake: there is no back-pressure. fetch_push and ex_valid are
// single-cycle qualifiers sampled on the rising clock edge; a push or pop
// the resolver cannot honour is dropped and reported through the sticky err.
// state_dbg exposes the resolver FSM state for observation.
interface branch_resolver_if
  import branch_types_pkg::*;
#(
  parameter int WADDR = REC_WADDR,
  parameter int CNTW  = 16
);
  logic             fetch_push;
  logic [WADDR-1:0] fetch_pc;
  logic             fetch_phit;
  logic [WADDR-1:0] fetch_target;
  logic             ex_valid;
  logic             ex_is_br;
  logic             ex_taken;
  logic [WADDR-1:0] ex_target;
  logic             upd_en;
  logic             upd_valid;
  logic [WADDR-1:0] upd_pc;
  logic [WADDR-1:0] upd_target;
  logic             flush;
  logic [WADDR-1:0] redirect_pc;
  logic             full;
  logic             empty;
  logic             err;
  logic [CNTW-1:0]  br_cnt;
  logic [CNTW-1:0]  miss_cnt;
  br_state_t        state_dbg;

  modport master (
    output fetch_push, fetch_pc, fetch_phit, fetch_target,
    output ex_valid, ex_is_br, ex_taken, ex_target,
    input  upd_en, upd_valid, upd_pc, upd_target, flush, redirect_pc,
    input  full, empty, err, br_cnt, miss_cnt, state_dbg
  );

  modport slave (
    input  fetch_push, fetch_pc, fetch_phit, fetch_target,
    input  ex_valid, ex_is_br, ex_taken, ex_target,
    output upd_en, upd_valid, upd_pc, upd_target, flush, redirect_pc,
    output full, empty, err, br_cnt, miss_cnt, state_dbg
  );
endinterface

// File: rtl/branch_resolver_pred_fifo.sv
// pred_fifo: in-order queue of DEPTH prediction records.
//   CLK, RST   : clock, asynchronous active-high reset
//   push, pop  : enqueue wr_data / dequeue head (caller guarantees legality)
//   clear      : drop all records; wins over push/pop
//   rd_data    : current head record
//   full/empty : occupancy after the most recent edge
// Pointers carry one extra wrap bit so equal indices can be told apart
// as empty (wrap bits equal) or full (wrap bits differ).
module pred_fifo
  import branch_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  pred_rec_t wr_data,
  output pred_rec_t rd_data,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);

  pred_rec_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: a slot is only read after it was written.
  always_ff @(posedge CLK) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: matches each instruction leaving EX with the BTB
// prediction recorded when it was fetched, issues the BTB install /
// invalidate write, and on a misprediction flushes IF/ID for one cycle
// with the corrected fetch address.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : branch_resolver_if.slave (fetch push, EX pop, BTB update,
//              flush/redirect, queue status, sticky err, statistics)
// WADDR must equal branch_types_pkg::REC_WADDR (the record width).
module branch_resolver
  import branch_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WADDR = REC_WADDR,
  parameter int CNTW  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  branch_resolver_if.slave  bus
);
  br_state_t        state_q, state_d;
  pred_rec_t        head, wr_rec;
  logic             fifo_full, fifo_empty, fifo_clear;
  logic             in_run, pop_fire, push_fire, miss_now, err_set;
  verdict_t         v;
  logic [WADDR-1:0] seq_pc;

  logic             upd_en_q, upd_valid_q, err_q;
  logic [WADDR-1:0] upd_pc_q, upd_target_q, redirect_q;
  logic [CNTW-1:0]  br_cnt_q, miss_cnt_q;

  assign wr_rec = '{pc: bus.fetch_pc, phit: bus.fetch_phit,
                    target: bus.fetch_target};

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (push_fire),
    .pop     (pop_fire),
    .clear   (fifo_clear),
    .wr_data (wr_rec),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Resolution and queue control. Everything arriving during FLUSH is
  // wrong-path, and a push in the mispredicting cycle is wrong-path too.
  assign in_run     = (state_q == BR_RUN);
  assign pop_fire   = in_run && bus.ex_valid && !fifo_empty;
  assign v          = judge(head.phit, bus.ex_is_br, bus.ex_taken,
                            bus.ex_target == head.target);
  assign miss_now   = pop_fire && v.miss;
  // A pop in the same cycle frees the slot, so push-when-full is fine then.
  assign push_fire  = in_run && bus.fetch_push && !miss_now &&
                      (!fifo_full || pop_fire);
  assign fifo_clear = (state_q == BR_FLUSH);
  assign err_set    = in_run &&
                      ((bus.fetch_push && fifo_full && !pop_fire) ||
                       (bus.ex_valid && fifo_empty));
  assign seq_pc     = head.pc + WADDR'(1);

  // FSM: state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= BR_RUN;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      BR_RUN:   if (miss_now) state_d = BR_FLUSH;
      BR_FLUSH: state_d = BR_RUN;
      default:  state_d = BR_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.flush     = (state_q == BR_FLUSH);
    bus.state_dbg = state_q;
  end

  // BTB update, redirect, sticky error and statistics registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      upd_en_q     <= 1'b0;
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_target_q <= '0;
      redirect_q   <= '0;
      err_q        <= 1'b0;
      br_cnt_q     <= '0;
      miss_cnt_q   <= '0;
    end else begin
      upd_en_q <= miss_now;
      if (miss_now) begin
        upd_valid_q  <= (v.res == RES_INSTALL);
        upd_pc_q     <= head.pc;
        upd_target_q <= bus.ex_target;
        redirect_q   <= v.use_seq ? seq_pc : bus.ex_target;
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNTW'(1);
      end
      if (pop_fire && bus.ex_is_br && br_cnt_q != '1)
        br_cnt_q <= br_cnt_q + CNTW'(1);
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.upd_en      = upd_en_q;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_pc      = upd_pc_q;
  assign bus.upd_target  = upd_target_q;
  assign bus.redirect_pc = redirect_q;
  assign bus.full        = fifo_full;
  assign bus.empty       = fifo_empty;
  assign bus.err         = err_q;
  assign bus.br_cnt      = br_cnt_q;
  assign bus.miss_cnt    = miss_cnt_q;
endmodule
